oka_seq_mult: RTL and testbench
===============================

OKA_SEQ_MULT -- requirements
Module: oka_seq_mult

Interface
REQ-001 SHALL have parameter N, default 205: operand width in bits; legal range N >= 2.
REQ-002 SHALL have derived localparam H, equal to (N+1)/2 (integer division): half-operand width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, N bits: GF(2)[x] polynomial; bit i is the coefficient of x^i.
REQ-008 SHALL have port b, input, N bits: second GF(2)[x] polynomial, same encoding as a.
REQ-009 SHALL have port out_valid, output, 1 bit: y holds a valid product.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts y.
REQ-011 SHALL have port y, output, 2N-1 bits: carry-less product a*b.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, MUL_E, MUL_O, MUL_M, DONE.
REQ-014 SHALL assert in_ready if and only if state == IDLE.
REQ-015 SHALL, on an edge where in_valid && in_ready, register a and b and go to MUL_E; in_valid SHALL be ignored in all other states.
REQ-016 SHALL split each operand into an even half (ae[i] = a[2i], i = 0..H-1) and an odd half (ao[i] = a[2i+1]); ao bits with 2i+1 >= N SHALL be 0. b SHALL be split the same way into be, bo.
REQ-017 SHALL instantiate exactly one combinational H x H carry-less sub-multiplier (2H-1-bit result), time-shared across the MUL_E, MUL_O and MUL_M states.
REQ-018 SHALL, in MUL_E, multiply ae by be and register the result as Pe on the exiting edge; next state MUL_O.
REQ-019 SHALL, in MUL_O, multiply ao by bo and register the result as Po on the exiting edge; next state MUL_M.
REQ-020 SHALL, in MUL_M, form Pm = (ae^ao)*(be^bo) combinationally and register y on the exiting edge; next state DONE.
REQ-021 SHALL compute y (overlap-free recombination) as y[2i] = Pe[i] ^ Po[i-1] for i = 0..N-1 (Po[-1] = 0), and y[2i+1] = Pm[i] ^ Pe[i] ^ Po[i] for i = 0..N-2.
REQ-022 SHALL have latency 3: accept on edge T, out_valid = 1 after edge T+3.
REQ-023 SHALL assert out_valid if and only if state == DONE, and SHALL hold y stable while out_valid && !out_ready.
REQ-024 SHALL, in DONE with out_ready = 1, return to IDLE on that edge; in_ready SHALL be 1 the following cycle, giving a minimum issue interval of 5 cycles.
REQ-025 SHALL keep y at its last value after the handshake until the next product is registered.
REQ-026 SHALL produce correct results for odd and even N; the top bits of Po and Pm are then 0 by construction.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force: state IDLE, out_valid 0, busy 0, y 0, Pe 0, Po 0, operand registers 0; in_ready = 1.
REQ-028 SHALL, on reset assertion in any state, abort the operation in progress with no partial output; the first accept after release SHALL behave as from power-up.

Verification
REQ-029 SHALL pass (N=4): a=4'b1111, b=4'b1111, out_ready=1 -> out_valid 3 cycles after accept, y=7'b1010101.
REQ-030 SHALL pass (N=4): a=4'b0011, b=4'b0011 -> y=7'b0000101; (N=5): a=5'b10000, b=5'b10000 -> y=9'b1_0000_0000.
REQ-031 SHALL pass (N=205): a=1<<204, b=1<<204 -> y bit 408 only set; a=1, b=1 -> y=1.
REQ-032 SHALL pass backpressure: out_ready=0 for 10 cycles in DONE -> out_valid held 1, y unchanged, in_ready 0, new in_valid ignored.
REQ-033 SHALL pass reset mid-op: rst_n low during MUL_O -> out_valid 0, y 0, in_ready 1 at once; next op after release is correct.
REQ-034 SHALL pass random back-to-back traffic (>= 10000 ops, N=205 and N=8) with random in_valid/out_ready -> every y equals a bitwise carry-less reference model, and no operation is lost or duplicated.

Source files
------------

// File: rtl/oka_seq_mult.sv
// oka_seq_mult: sequential carry-less GF(2)[x] multiplier using an even/odd
// (overlap-free) Karatsuba split. One H x H carry-less core is reused over
// three cycles to form Pe = ae*be, Po = ao*bo and Pm = (ae^ao)*(be^bo). The
// product is then recombined without overlapping additions.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b     [N-1:0]     : polynomials, bit i = coefficient of x^i
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   y        [2N-2:0]    : carry-less product a*b, held until next result
//   busy                 : high in every state except IDLE
module oka_seq_mult #(
    parameter int unsigned N = 205
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y,
    output logic           busy
);

    localparam int unsigned H  = (N + 1) / 2;
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned YW = 2 * N - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL_E = 3'd1,
        S_MUL_O = 3'd2,
        S_MUL_M = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [PW-1:0]   r_pe;
    logic [N-2:0]    r_po;
    logic [YW-1:0]   r_y;

    logic            w_accept;
    logic            w_sel_e;
    logic            w_sel_o;
    logic            w_ld_pe;
    logic            w_ld_po;
    logic            w_ld_y;

    logic [H-1:0]    w_ae;
    logic [H-1:0]    w_ao;
    logic [H-1:0]    w_be;
    logic [H-1:0]    w_bo;
    logic [H-1:0]    w_mx;
    logic [H-1:0]    w_mz;
    logic [PW-1:0]   w_prod;
    logic [N-1:0]    w_pe_x;
    logic [YW-1:0]   w_y_nxt;

    // H x H carry-less multiply (shift-and-xor over the multiplier bits)
    function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] z);
        logic [PW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < H; i++) begin
            if (z[i]) begin
                acc = acc ^ (PW'(x) << i);
            end
        end
        return acc;
    endfunction

    // Even/odd split of the registered operands; odd halves zero-padded for odd N
    for (genvar gi = 0; gi < H; gi++) begin : g_split
        assign w_ae[gi] = r_a[2*gi];
        assign w_be[gi] = r_b[2*gi];
        if (2 * gi + 1 < N) begin : g_odd
            assign w_ao[gi] = r_a[2*gi+1];
            assign w_bo[gi] = r_b[2*gi+1];
        end else begin : g_pad
            assign w_ao[gi] = 1'b0;
            assign w_bo[gi] = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_MUL_E;
            S_MUL_E: w_state_nxt = S_MUL_O;
            S_MUL_O: w_state_nxt = S_MUL_M;
            S_MUL_M: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State decode: handshake flags and datapath controls
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_sel_e   = 1'b0;
        w_sel_o   = 1'b0;
        w_ld_pe   = 1'b0;
        w_ld_po   = 1'b0;
        w_ld_y    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
            end
            S_MUL_E: begin
                busy    = 1'b1;
                w_sel_e = 1'b1;
                w_ld_pe = 1'b1;
            end
            S_MUL_O: begin
                busy    = 1'b1;
                w_sel_o = 1'b1;
                w_ld_po = 1'b1;
            end
            S_MUL_M: begin
                busy   = 1'b1;
                w_ld_y = 1'b1;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand mux into the single shared core; the middle term is the default
    always_comb begin
        w_mx = w_ae ^ w_ao;
        w_mz = w_be ^ w_bo;
        if (w_sel_e) begin
            w_mx = w_ae;
            w_mz = w_be;
        end else if (w_sel_o) begin
            w_mx = w_ao;
            w_mz = w_bo;
        end
    end

    assign w_prod = clmul_h(w_mx, w_mz);

    // Pe has one bit fewer than needed for even N; its missing top bit is 0
    assign w_pe_x = N'(r_pe);

    // Overlap-free recombination: even bits from Pe/Po, odd bits from Pm^Pe^Po
    assign w_y_nxt[0] = w_pe_x[0];
    for (genvar gi = 1; gi < N; gi++) begin : g_even
        assign w_y_nxt[2*gi] = w_pe_x[gi] ^ r_po[gi-1];
    end
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_oddy
        assign w_y_nxt[2*gi+1] = w_prod[gi] ^ w_pe_x[gi] ^ r_po[gi];
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_pe <= '0;
            r_po <= '0;
            r_y  <= '0;
        end else begin
            if (w_accept) begin
                r_a <= a;
                r_b <= b;
            end
            if (w_ld_pe) begin
                r_pe <= w_prod;
            end
            if (w_ld_po) begin
                r_po <= w_prod[N-2:0];
            end
            if (w_ld_y) begin
                r_y <= w_y_nxt;
            end
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_oka_seq_mult.sv
// Testbench for oka_seq_mult: four instances (N = 205, 4, 5, 8) on a shared
// clock and reset, checked against a schoolbook carry-less product model.
module tb_oka_seq_mult;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;

    logic         in_valid_s  [4];
    logic         out_ready_s [4];
    logic [204:0] a_s         [4];
    logic [204:0] b_s         [4];
    wire          in_ready_s  [4];
    wire          out_valid_s [4];
    wire          busy_s      [4];
    wire  [408:0] y_s         [4];

    wire  [408:0] y0;
    wire  [6:0]   y1;
    wire  [8:0]   y2;
    wire  [14:0]  y3;

    int tests_run    = 0;
    int tests_failed = 0;

    assign y_s[0] = y0;
    assign y_s[1] = 409'(y1);
    assign y_s[2] = 409'(y2);
    assign y_s[3] = 409'(y3);

    always #5 clk = ~clk;

    oka_seq_mult #(.N(205)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .y(y0), .busy(busy_s[0])
    );

    oka_seq_mult #(.N(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1][3:0]), .b(b_s[1][3:0]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .y(y1), .busy(busy_s[1])
    );

    oka_seq_mult #(.N(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2][4:0]), .b(b_s[2][4:0]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .y(y2), .busy(busy_s[2])
    );

    oka_seq_mult #(.N(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
        .a(a_s[3][7:0]), .b(b_s[3][7:0]),
        .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]),
        .y(y3), .busy(busy_s[3])
    );

    function automatic int nw(input int k);
        case (k)
            0:       return 205;
            1:       return 4;
            2:       return 5;
            default: return 8;
        endcase
    endfunction

    // Reference: sum over set bits of z of x shifted, addition being xor
    function automatic logic [408:0] clmul_ref(input logic [204:0] x, input logic [204:0] z);
        logic [408:0] acc;
        acc = '0;
        for (int i = 0; i < 205; i++) begin
            if (z[i]) acc ^= (409'(x) << i);
        end
        return acc;
    endfunction

    // Random operand of width w, with occasional all-ones / zero / top-bit-only values
    function automatic logic [204:0] rand_op(input int w);
        logic [223:0] r;
        logic [204:0] v;
        logic [204:0] m;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(15))
            0:       v = '1;
            1:       v = '0;
            2:       v = 205'(1) << (w - 1);
            default: v = r[204:0];
        endcase
        m = (205'(1) << w) - 205'(1);
        return v & m;
    endfunction

    // One full operation with latency, result and release checks
    task automatic op_check(input int k, input logic [204:0] av, input logic [204:0] bv,
                            input logic [408:0] exp_y, input string name);
        int t;
        t = 0;
        @(negedge clk);
        in_valid_s[k]  = 1'b1;
        a_s[k]         = av;
        b_s[k]         = bv;
        out_ready_s[k] = 1'b1;
        while (in_ready_s[k] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        tests_run++;
        if (in_ready_s[k] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept: in_ready=%b, expected 1", name, in_ready_s[k]);
            in_valid_s[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_s[k] = 1'b0;
        a_s[k] = rand_op(nw(k));
        b_s[k] = rand_op(nw(k));
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid_s[k] !== 1'(c == 4) || busy_s[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_lat%0d: out_valid=%b busy=%b, expected out_valid=%b busy=1",
                         name, c, out_valid_s[k], busy_s[k], 1'(c == 4));
            end
        end
        tests_run++;
        if (y_s[k] !== exp_y) begin
            tests_failed++;
            $display("FAIL %s_y: got %h expected %h", name, y_s[k], exp_y);
        end
        @(negedge clk);
        tests_run++;
        if (in_ready_s[k] !== 1'b1 || out_valid_s[k] !== 1'b0 || busy_s[k] !== 1'b0 || y_s[k] !== exp_y) begin
            tests_failed++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b busy=%b y=%h, expected 1 0 0 %h",
                     name, in_ready_s[k], out_valid_s[k], busy_s[k], y_s[k], exp_y);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
            a_s[k]         = '0;
            b_s[k]         = '0;
        end
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (in_ready_s[k] !== 1'b1 || out_valid_s[k] !== 1'b0 || busy_s[k] !== 1'b0 || y_s[k] !== '0) begin
                tests_failed++;
                $display("FAIL reset_state%0d: in_ready=%b out_valid=%b busy=%b y=%h, expected 1 0 0 0",
                         k, in_ready_s[k], out_valid_s[k], busy_s[k], y_s[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [204:0] av;
        logic [204:0] bv;
        op_check(1, 205'(4'b1111), 205'(4'b1111), 409'(7'b1010101), "n4_ones");
        op_check(1, 205'(4'b0011), 205'(4'b0011), 409'(7'b0000101), "n4_0011");
        op_check(2, 205'(5'b10000), 205'(5'b10000), 409'(9'b1_0000_0000), "n5_top");
        op_check(0, 205'(1) << 204, 205'(1) << 204, 409'(1) << 408, "n205_top");
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 3; r++) begin
                av = rand_op(nw(k));
                bv = rand_op(nw(k));
                op_check(k, av, bv, clmul_ref(av, bv), "rand_single");
            end
        end
        op_check(0, 205'(1), 205'(1), 409'(1), "n205_one");
    endtask

    task automatic test_reset_midop();
        logic         seen;
        logic [204:0] av;
        logic [204:0] bv;
        seen = 1'b0;
        @(negedge clk);
        in_valid_s[0]  = 1'b1;
        a_s[0]         = rand_op(205);
        b_s[0]         = rand_op(205);
        out_ready_s[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid_s[0] !== 1'b0 || y_s[0] !== '0 || in_ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_reset: out_valid=%b y=%h in_ready=%b busy=%b, expected 0 0 1 0",
                     out_valid_s[0], y_s[0], in_ready_s[0], busy_s[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_s[0] !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL midop_no_output: out_valid seen=%b, expected 0", seen);
        end
        av = rand_op(205);
        bv = rand_op(205);
        op_check(0, av, bv, clmul_ref(av, bv), "after_reset");
    endtask

    task automatic test_backpressure();
        logic [204:0] av;
        logic [204:0] bv;
        logic [408:0] exp_y;
        int           t;
        av    = rand_op(205);
        bv    = rand_op(205);
        exp_y = clmul_ref(av, bv);
        @(negedge clk);
        in_valid_s[0]  = 1'b1;
        a_s[0]         = av;
        b_s[0]         = bv;
        out_ready_s[0] = 1'b0;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        t = 0;
        while (out_valid_s[0] !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        tests_run++;
        if (out_valid_s[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_reach_done: out_valid=%b, expected 1", out_valid_s[0]);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid_s[0] = 1'b1;
            a_s[0] = rand_op(205);
            b_s[0] = rand_op(205);
            tests_run++;
            if (out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0 || y_s[0] !== exp_y) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b y=%h, expected 1 0 %h",
                         c, out_valid_s[0], in_ready_s[0], y_s[0], exp_y);
            end
            @(negedge clk);
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || y_s[0] !== exp_y) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b y=%h, expected 0 1 %h",
                     out_valid_s[0], in_ready_s[0], y_s[0], exp_y);
        end
        @(negedge clk);
        tests_run++;
        if (y_s[0] !== exp_y || busy_s[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_retain: y=%h busy=%b, expected %h 0", y_s[0], busy_s[0], exp_y);
        end
    endtask

    // Random valid/ready traffic; every accepted op must come out once, in order
    task automatic random_traffic(input int k, input int nops, input string name);
        logic [408:0] q[$];
        logic [408:0] exp_y;
        logic         seen;
        int           sent;
        int           got;
        int           cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        seen = 1'b0;
        while (got < nops && cyc < nops * 12) begin
            @(negedge clk);
            cyc++;
            if (sent < nops && $urandom_range(7) != 0) begin
                in_valid_s[k] = 1'b1;
                a_s[k] = rand_op(nw(k));
                b_s[k] = rand_op(nw(k));
            end else begin
                in_valid_s[k] = 1'b0;
            end
            out_ready_s[k] = ($urandom_range(7) != 0);
            if (in_valid_s[k] && in_ready_s[k] === 1'b1) begin
                q.push_back(clmul_ref(a_s[k], b_s[k]));
                sent++;
            end
            if (out_valid_s[k] === 1'b1 && out_ready_s[k]) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s_spurious: out_valid=1 with no outstanding op, expected 0", name);
                end else begin
                    exp_y = q.pop_front();
                    if (y_s[k] !== exp_y) begin
                        tests_failed++;
                        $display("FAIL %s_y%0d: got %h expected %h", name, got, y_s[k], exp_y);
                    end
                end
                got++;
            end
        end
        in_valid_s[k]  = 1'b0;
        out_ready_s[k] = 1'b1;
        tests_run++;
        if (got != nops || sent != nops || q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_count: sent %0d got %0d pending %0d, expected %0d %0d 0",
                     name, sent, got, q.size(), nops, nops);
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid_s[k] !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL %s_dup: extra out_valid seen=%b, expected 0", name, seen);
        end
    endtask

    task automatic test_random_traffic();
        fork
            random_traffic(0, 10000, "rnd205");
            random_traffic(3, 10000, "rnd8");
        join
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_midop();
        test_backpressure();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
